spikehard_output_packer: RTL and testbench

// Multi-channel successor to the single-channel output path of the accelerator top. Collects output spikes from
// NUM_CHANNELS output cores, ORs them into a per-tick spike bitmap, and on each tick packs the bitmap into
// DMA_BUS_WIDTH words in a FIFO feeding the DMA write channel. Also holds sticky per-source error latches for debug.

---
 rtl/spikehard_output_packer.sv | 171 +++++++++++++++++
 tb/tb_spikehard_output_packer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spikehard_output_packer.sv
// Spike output packer: ORs per-channel output spikes into a per-tick bitmap and streams
// each closed frame as DMA-width words through a small FIFO, with sticky debug flags.
module spikehard_output_packer #(
  parameter int NUM_CHANNELS    = 2,
  parameter int NUM_OUTPUTS     = 16,
  parameter int DMA_BUS_WIDTH   = 32,
  parameter int FIFO_DEPTH      = 8,
  parameter int NUM_ERR_SOURCES = 2,
  localparam int IDX_W = $clog2(NUM_OUTPUTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [NUM_CHANNELS-1:0]       spike_valid,
  input  logic [NUM_CHANNELS*IDX_W-1:0] spike_idx,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DMA_BUS_WIDTH-1:0]      out_data,
  output logic                          out_last,
  input  logic [NUM_ERR_SOURCES-1:0]    err_in,
  input  logic                          clr_err,
  output logic [NUM_ERR_SOURCES-1:0]    err_latch,
  output logic                          bad_idx,
  output logic                          overflow,
  output logic [15:0]                   drop_count
);

  localparam int WORDS = (NUM_OUTPUTS + DMA_BUS_WIDTH - 1) / DMA_BUS_WIDTH;
  localparam int PAD_W = WORDS * DMA_BUS_WIDTH;
  localparam int CNT_W = $clog2(WORDS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W:0]   NOUT      = (IDX_W + 1)'(NUM_OUTPUTS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
  localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e                     state_q, state_d;
  logic [NUM_OUTPUTS-1:0]     bitmap_q, bitmap_d;
  logic [PAD_W-1:0]           snap_q, snap_d;
  logic [CNT_W-1:0]           word_cnt_q, word_cnt_d;
  logic                       overflow_q, overflow_d;
  logic [15:0]                drop_q, drop_d;
  logic [NUM_ERR_SOURCES-1:0] err_q, err_d;
  logic                       bad_q, bad_d;

  logic [DMA_BUS_WIDTH:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]           occ_q;

  logic [NUM_OUTPUTS-1:0]     incoming;
  logic                       bad_hit;
  logic                       push, pop, full;
  logic [DMA_BUS_WIDTH-1:0]   push_word;
  logic                       push_last;

  // Out-of-range indices are dropped here and only flagged through bad_idx.
  always_comb begin
    logic [IDX_W-1:0] idx_c;
    incoming = '0;
    bad_hit  = 1'b0;
    idx_c    = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      idx_c = spike_idx[c*IDX_W +: IDX_W];
      if (spike_valid[c]) begin
        if ({1'b0, idx_c} < NOUT) incoming[idx_c] = 1'b1;
        else                      bad_hit = 1'b1;
      end
    end
  end

  assign full      = (occ_q == FULL_OCC);
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid && out_ready;
  assign push_last = (word_cnt_q == LAST_WORD);

  always_comb begin
    push_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (word_cnt_q == CNT_W'(w)) push_word = snap_q[w*DMA_BUS_WIDTH +: DMA_BUS_WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    bitmap_d   = bitmap_q | incoming;
    snap_d     = snap_q;
    word_cnt_d = word_cnt_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          snap_d     = PAD_W'(bitmap_q | incoming);
          bitmap_d   = '0;
          word_cnt_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (!full) begin
          push       = 1'b1;
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (push_last) state_d = IDLE;
        end
        // A tick while the previous frame is still draining loses the new frame.
        if (tick) begin
          bitmap_d   = '0;
          overflow_d = 1'b1;
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_d = clr_err ? err_in  : (err_q | err_in);
  assign bad_d = clr_err ? bad_hit : (bad_q | bad_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bitmap_q   <= '0;
      snap_q     <= '0;
      word_cnt_q <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      err_q      <= '0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitmap_q   <= bitmap_d;
      snap_q     <= snap_d;
      word_cnt_q <= word_cnt_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
      bad_q      <= bad_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {push_last, push_word};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign out_data   = mem_q[rd_ptr_q][DMA_BUS_WIDTH-1:0];
  assign out_last   = mem_q[rd_ptr_q][DMA_BUS_WIDTH];
  assign err_latch  = err_q;
  assign bad_idx    = bad_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_spikehard_output_packer.sv
// Bench for spikehard_output_packer: directed scenarios plus randomized frames checked
// against a bitmap model; a second instance covers a 48-output, two-word frame.
module tb_spikehard_output_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        tick, out_ready, clr_err;
  logic [1:0]  spike_valid, err_in;
  logic [7:0]  spike_idx;
  logic        out_valid, out_last, bad_idx, overflow;
  logic [31:0] out_data;
  logic [1:0]  err_latch;
  logic [15:0] drop_count;

  logic        tick_w, ready_w, clr_w;
  logic [1:0]  sv_w, err_w;
  logic [11:0] si_w;
  logic        valid_w, last_w, bad_w, ovf_w;
  logic [31:0] data_w;
  logic [1:0]  errl_w;
  logic [15:0] drop_w;

  int n_checks = 0;
  int n_fail   = 0;

  spikehard_output_packer #(.NUM_CHANNELS(2), .NUM_OUTPUTS(16), .DMA_BUS_WIDTH(32),
                            .FIFO_DEPTH(8), .NUM_ERR_SOURCES(2)) dut (
    .clk(clk), .rst(rst), .tick(tick), .spike_valid(spike_valid), .spike_idx(spike_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err_in(err_in), .clr_err(clr_err), .err_latch(err_latch), .bad_idx(bad_idx),
    .overflow(overflow), .drop_count(drop_count));

  spikehard_output_packer #(.NUM_CHANNELS(2), .NUM_OUTPUTS(48), .DMA_BUS_WIDTH(32),
                            .FIFO_DEPTH(8), .NUM_ERR_SOURCES(2)) dut48 (
    .clk(clk), .rst(rst), .tick(tick_w), .spike_valid(sv_w), .spike_idx(si_w),
    .out_valid(valid_w), .out_ready(ready_w), .out_data(data_w), .out_last(last_w),
    .err_in(err_w), .clr_err(clr_w), .err_latch(errl_w), .bad_idx(bad_w),
    .overflow(ovf_w), .drop_count(drop_w));

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick = 0; out_ready = 0; clr_err = 0; spike_valid = 0; spike_idx = 0; err_in = 0;
    tick_w = 0; ready_w = 0; clr_w = 0; sv_w = 0; si_w = 0; err_w = 0;
    cyc(2);
    n_checks++;
    if ({out_valid, out_last, out_data} !== 34'h0) begin
      n_fail++; $display("FAIL reset_fifo: got valid=%b last=%b data=%h want all 0", out_valid, out_last, out_data);
    end
    rst = 1'b0;
    cyc(1);
    n_checks++;
    if ({err_latch, bad_idx, overflow, drop_count, out_valid} !== 21'h0) begin
      n_fail++; $display("FAIL reset_flags: got err=%b bad=%b ovf=%b drop=%0d valid=%b want all 0",
                         err_latch, bad_idx, overflow, drop_count, out_valid);
    end
  endtask

  task automatic test_basic();
    out_ready = 0;
    spike_valid = 2'b11; spike_idx = {4'd3, 4'd3};
    cyc(1);
    spike_valid = 0; tick = 1;
    cyc(1);
    tick = 0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_latency_t1: got valid=%b want 0", out_valid);
    end
    cyc(1);
    n_checks++;
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 32'h0000_0008}) begin
      n_fail++; $display("FAIL basic_word: got valid=%b last=%b data=%h want 1 1 00000008", out_valid, out_last, out_data);
    end
    out_ready = 1;
    cyc(1);
    out_ready = 0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_pop: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_wide();
    logic [32:0] exp_w [2];
    int got, waited;
    exp_w[0] = {1'b0, 32'h0000_0001};
    exp_w[1] = {1'b1, 32'h0000_8100};
    ready_w = 0;
    sv_w = 2'b11; si_w = {6'd40, 6'd0};
    cyc(1);
    sv_w = 2'b11; si_w = {6'd50, 6'd47};
    cyc(1);
    sv_w = 0; tick_w = 1;
    cyc(1);
    tick_w = 0;
    cyc(3);
    n_checks++;
    if (bad_w !== 1'b1) begin
      n_fail++; $display("FAIL wide_bad_idx: got %b want 1", bad_w);
    end
    ready_w = 1;
    got = 0; waited = 0;
    while (got < 2 && waited < 20) begin
      if (valid_w) begin
        n_checks++;
        if ({last_w, data_w} !== exp_w[got]) begin
          n_fail++; $display("FAIL wide_word%0d: got last=%b data=%h want %h", got, last_w, data_w, exp_w[got]);
        end
        got++;
      end
      cyc(1); waited++;
    end
    ready_w = 0;
    n_checks++;
    if (got != 2) begin
      n_fail++; $display("FAIL wide_timeout: got %0d words want 2", got);
    end
    clr_w = 1;
    cyc(1);
    clr_w = 0;
    n_checks++;
    if (bad_w !== 1'b0) begin
      n_fail++; $display("FAIL wide_bad_clr: got %b want 0", bad_w);
    end
  endtask

  task automatic test_coincident();
    logic [31:0] exp_d [2];
    int got, waited;
    exp_d[0] = 32'h0000_0020;
    exp_d[1] = 32'h0000_0000;
    out_ready = 0;
    spike_valid = 2'b01; spike_idx = 8'h05; tick = 1;
    cyc(1);
    spike_valid = 0; tick = 0;
    cyc(3);
    tick = 1;
    cyc(1);
    tick = 0;
    cyc(3);
    out_ready = 1;
    got = 0; waited = 0;
    while (got < 2 && waited < 20) begin
      if (out_valid) begin
        n_checks++;
        if ({out_last, out_data} !== {1'b1, exp_d[got]}) begin
          n_fail++; $display("FAIL coincident_frame%0d: got last=%b data=%h want 1 %h", got, out_last, out_data, exp_d[got]);
        end
        got++;
      end
      cyc(1); waited++;
    end
    out_ready = 0;
    n_checks++;
    if (got != 2) begin
      n_fail++; $display("FAIL coincident_timeout: got %0d frames want 2", got);
    end
  endtask

  task automatic test_random(input int frames);
    logic [15:0] bm;
    logic [32:0] held;
    bit have_held;
    int got, waited;
    for (int f = 0; f < frames; f++) begin
      bm = '0;
      repeat ($urandom_range(4, 0)) begin
        spike_valid = 2'($urandom); spike_idx = 8'($urandom);
        for (int c = 0; c < 2; c++) if (spike_valid[c]) bm[spike_idx[c*4 +: 4]] = 1'b1;
        cyc(1);
      end
      spike_valid = 2'($urandom); spike_idx = 8'($urandom); tick = 1;
      for (int c = 0; c < 2; c++) if (spike_valid[c]) bm[spike_idx[c*4 +: 4]] = 1'b1;
      cyc(1);
      spike_valid = 0; tick = 0;
      got = 0; waited = 0; have_held = 0; held = '0;
      while (got == 0 && waited < 40) begin
        out_ready = ($urandom_range(3, 0) != 0);
        if (out_valid) begin
          if (have_held) begin
            n_checks++;
            if ({out_last, out_data} !== held) begin
              n_fail++; $display("FAIL random_hold f%0d: got %h want %h", f, {out_last, out_data}, held);
            end
          end
          if (out_ready) begin
            n_checks++;
            if ({out_last, out_data} !== {1'b1, 16'h0, bm}) begin
              n_fail++; $display("FAIL random_frame f%0d: got last=%b data=%h want 1 %h", f, out_last, out_data, {16'h0, bm});
            end
            got = 1;
          end else begin
            held = {out_last, out_data}; have_held = 1;
          end
        end
        cyc(1); waited++;
      end
      out_ready = 0;
      if (got == 0) begin
        n_checks++; n_fail++; $display("FAIL random_timeout f%0d: got no word want 1", f);
      end
    end
    n_checks++;
    if ({overflow, drop_count} !== 17'h0) begin
      n_fail++; $display("FAIL random_no_drop: got ovf=%b drop=%0d want 0 0", overflow, drop_count);
    end
  endtask

  task automatic test_overflow();
    int got, waited;
    out_ready = 0;
    for (int k = 0; k < 9; k++) begin
      spike_valid = 2'b01; spike_idx = 8'(k);
      cyc(1);
      spike_valid = 0; tick = 1;
      cyc(1);
      tick = 0;
      cyc(2);
    end
    n_checks++;
    if ({overflow, drop_count} !== 17'h0) begin
      n_fail++; $display("FAIL ovf_before: got ovf=%b drop=%0d want 0 0", overflow, drop_count);
    end
    spike_valid = 2'b01; spike_idx = 8'd12; tick = 1;
    cyc(1);
    spike_valid = 0; tick = 0;
    n_checks++;
    if ({overflow, drop_count} !== {1'b1, 16'd1}) begin
      n_fail++; $display("FAIL ovf_after: got ovf=%b drop=%0d want 1 1", overflow, drop_count);
    end
    cyc(2);
    out_ready = 1;
    got = 0; waited = 0;
    while (got < 9 && waited < 40) begin
      if (out_valid) begin
        n_checks++;
        if ({out_last, out_data} !== {1'b1, 32'(1) << got}) begin
          n_fail++; $display("FAIL ovf_order%0d: got last=%b data=%h want 1 %h", got, out_last, out_data, 32'(1) << got);
        end
        got++;
      end
      cyc(1); waited++;
    end
    n_checks++;
    if (got != 9) begin
      n_fail++; $display("FAIL ovf_timeout: got %0d frames want 9", got);
    end
    cyc(3);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_dropped_frame: got valid=%b data=%h want valid 0", out_valid, out_data);
    end
    out_ready = 0;
  endtask

  task automatic test_errors();
    err_in = 2'b10;
    cyc(1);
    err_in = 2'b00;
    n_checks++;
    if (err_latch !== 2'b10) begin
      n_fail++; $display("FAIL err_set: got %b want 10", err_latch);
    end
    err_in = 2'b01;
    cyc(1);
    err_in = 2'b00;
    n_checks++;
    if (err_latch !== 2'b11) begin
      n_fail++; $display("FAIL err_sticky: got %b want 11", err_latch);
    end
    clr_err = 1; err_in = 2'b10;
    cyc(1);
    n_checks++;
    if (err_latch !== 2'b10) begin
      n_fail++; $display("FAIL err_set_wins: got %b want 10", err_latch);
    end
    err_in = 2'b00;
    cyc(1);
    clr_err = 0;
    n_checks++;
    if (err_latch !== 2'b00) begin
      n_fail++; $display("FAIL err_clear: got %b want 00", err_latch);
    end
    n_checks++;
    if ({overflow, drop_count} !== {1'b1, 16'd1}) begin
      n_fail++; $display("FAIL err_clr_keeps_ovf: got ovf=%b drop=%0d want 1 1", overflow, drop_count);
    end
  endtask

  task automatic test_reset_mid_send();
    int got, waited;
    out_ready = 0;
    for (int k = 1; k <= 3; k++) begin
      spike_valid = 2'b01; spike_idx = 8'(k);
      cyc(1);
      spike_valid = 0; tick = 1;
      cyc(1);
      tick = 0;
      cyc(2);
    end
    spike_valid = 2'b01; spike_idx = 8'd4; tick = 1;
    cyc(1);
    spike_valid = 0; tick = 0;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_valid: got %b want 1", out_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, overflow, drop_count, out_data} !== 50'h0) begin
      n_fail++; $display("FAIL rst_async: got valid=%b ovf=%b drop=%0d data=%h want all 0",
                         out_valid, overflow, drop_count, out_data);
    end
    cyc(2);
    rst = 1'b0;
    cyc(1);
    spike_valid = 2'b10; spike_idx = {4'd9, 4'd0};
    cyc(1);
    spike_valid = 0; tick = 1;
    cyc(1);
    tick = 0;
    out_ready = 1;
    got = 0; waited = 0;
    while (got == 0 && waited < 20) begin
      if (out_valid) begin
        n_checks++;
        if ({out_last, out_data} !== {1'b1, 32'h0000_0200}) begin
          n_fail++; $display("FAIL rst_clean_frame: got last=%b data=%h want 1 00000200", out_last, out_data);
        end
        got = 1;
      end
      cyc(1); waited++;
    end
    n_checks++;
    if (got != 1) begin
      n_fail++; $display("FAIL rst_clean_timeout: got no word want 1");
    end
    cyc(3);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_leftover: got valid=%b data=%h want valid 0", out_valid, out_data);
    end
    out_ready = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wide();
    test_coincident();
    test_random(40);
    test_overflow();
    test_errors();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
